// File: rtl/pipe_stage.sv
// Single pipeline register stage with valid/ready handshake, flush and bubble clearing.
// Define PIPE_STAGE_SKID_EN to add a skid register so in_ready comes from a flop.
module pipe_stage #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       CTRL_W  = 4,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    // Ones over the low CTRL_W bits; empty when CTRL_W is 0, all ones when CTRL_W == DATA_W.
    localparam logic [DATA_W-1:0] CTRL_MASK = ~({DATA_W{1'b1}} << CTRL_W);

    logic [DATA_W-1:0] bubble;
    logic              in_xfer;
    logic              out_xfer;

    assign bubble   = in_data & ~CTRL_MASK;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] skid_data;
    logic              ready_q;

    // ready_q is held high through reset so the stage accepts on the first cycle after release.
    assign in_ready = ready_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= RST_VAL;
            skid_data <= '0;
            ready_q   <= 1'b1;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_data  <= bubble;
            ready_q   <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                    end else begin
                        out_data  <= bubble;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_data  <= in_data;
                    end else if (in_xfer) begin
                        state     <= ST_FULL;
                        skid_data <= in_data;
                        ready_q   <= 1'b0;
                    end else if (out_xfer) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                        out_data  <= bubble;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state    <= ST_ONE;
                        out_data <= skid_data;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    out_data  <= bubble;
                    ready_q   <= 1'b1;
                end
            endcase
        end
    end

`else

    assign in_ready = !rst && (out_ready || !out_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= RST_VAL;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= bubble;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_xfer || !out_valid) begin
            out_valid <= 1'b0;
            out_data  <= bubble;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: queue-based occupancy model, directed cases, random traffic.
// Honours PIPE_STAGE_SKID_EN to select the expected buffering depth.
module tb_pipe_stage;

    localparam logic [31:0] RV = 32'hDEAD_0000;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;

    int checks = 0;
    int failures = 0;

    logic [31:0] q[$];
    bit          chk_en = 1'b0;
    bit          after_rst = 1'b0;

    pipe_stage #(
        .DATA_W (32),
        .CTRL_W (4),
        .RST_VAL(RV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endfunction

    // Capacity model: one slot without skid (freed by a same-cycle output), two with skid.
    function automatic bit model_ready();
        if (rst) return 1'b0;
        if (SKID) return q.size() < 2;
        return out_ready || (q.size() == 0);
    endfunction

    always @(posedge clk) begin
        bit ir, ox, ix;
        ir = model_ready();
        if (rst) begin
            q.delete();
            chk_en    = 1'b1;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (flush) begin
                q.delete();
            end else begin
                ox = (q.size() > 0) && out_ready;
                ix = in_valid && ir;
                if (ox) void'(q.pop_front());
                if (ix) q.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
            check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            if (after_rst)
                check("out_data_rst", out_data, RV);
            else if (q.size() > 0)
                check("out_data", out_data, q[0]);
            else
                check("bubble_ctrl", out_data & 32'hF, 32'h0);
        end
    end

    task automatic drive(input bit r, input bit f, input bit iv, input logic [31:0] d, input bit ordy);
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #2;
    endtask

    initial begin
        int pct;
        // reset
        drive(1, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 32'h0, 0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h0);
        drive(0, 0, 0, $urandom, 1);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'hDEAD_0000);
        check("release_in_ready", {31'b0, in_ready}, 32'h1);

        // back-to-back stream
        drive(0, 0, 1, 32'h11, 1);
        drive(0, 0, 1, 32'h22, 1);
        check("stream0", out_data, 32'h11);
        drive(0, 0, 1, 32'h33, 1);
        check("stream1", out_data, 32'h22);
        drive(0, 0, 0, 32'h0, 1);
        check("stream2", out_data, 32'h33);
        check("stream2_valid", {31'b0, out_valid}, 32'h1);
        drive(0, 0, 0, 32'h0, 1);
        check("stream_drain", {31'b0, out_valid}, 32'h0);

        // stall with pending input
        drive(0, 0, 1, 32'h44, 1);
        drive(0, 0, 1, 32'h55, 0);
        check("stall1_data", out_data, 32'h44);
        check("stall1_ready", {31'b0, in_ready}, {31'b0, SKID});
        drive(0, 0, 1, 32'h55, 0);
        check("stall2_data", out_data, 32'h44);
        check("stall2_ready", {31'b0, in_ready}, 32'h0);
        drive(0, 0, 1, 32'h55, 0);
        check("stall3_data", out_data, 32'h44);
        check("stall3_ready", {31'b0, in_ready}, 32'h0);
        // with skid: FULL, out and in on the same edge -> skid drains, 0x77 refused
        drive(0, 0, 1, SKID ? 32'h77 : 32'h55, 1);
        check("release_data", out_data, 32'h44);
        check("release_ready", {31'b0, in_ready}, {31'b0, !SKID});
        drive(0, 0, 0, 32'h0, 1);
        check("second_data", out_data, 32'h55);
        check("second_valid", {31'b0, out_valid}, 32'h1);
        drive(0, 0, 0, 32'h0, 1);
        check("after_stall_empty", {31'b0, out_valid}, 32'h0);

        // flush kills held and incoming payloads
        drive(0, 0, 1, 32'h0000_000F, 1);
        drive(0, 1, 1, 32'h66, 0);
        check("pre_flush_data", out_data, 32'h0000_000F);
        drive(0, 0, 0, 32'h0, 1);
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        check("flush_ctrl", out_data & 32'hF, 32'h0);
        drive(0, 0, 0, 32'h0, 1);
        check("flush_no_66", {31'b0, out_valid}, 32'h0);

        // random traffic
        pct = 60;
        for (int i = 0; i < 10000; i++) begin
            if (i % 1000 == 0) pct = (i / 1000) % 3 == 0 ? 100 : ((i / 1000) % 3 == 1 ? 60 : 20);
            drive($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 99) < 70, $urandom,
                  $urandom_range(0, 99) < pct);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 32'h0, 1);
        check("final_empty", {31'b0, out_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 Parameter CTRL_W, default 4, number of low payload bits treated as write-enable/control bits; 0 <= CTRL_W <= DATA_W.
REQ-003 Parameter RST_VAL, default 0, DATA_W-bit value loaded into out_data on reset.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  stage can accept a payload this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 flush  input  1  synchronous kill of all held payloads (branch/exception squash).
REQ-010 out_valid  output  1  out_data holds a live payload.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle (deasserted = stall).
REQ-012 out_data  output  DATA_W  registered payload to downstream stage.

Function
REQ-013 Input transfer SHALL occur at a posedge with in_valid=1 and in_ready=1; output transfer SHALL occur at a posedge with out_valid=1 and out_ready=1.
REQ-014 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by flush.
REQ-015 Latency SHALL be 1 cycle: a payload accepted at edge N with the stage empty appears on out_data with out_valid=1 after edge N.
REQ-016 out_data SHALL change only on a posedge; no combinational path from in_data to out_data.
REQ-017 Bubble rule: when out_valid is 0 after an edge, out_data[CTRL_W-1:0] SHALL be 0 (upper bits don't-care, implementation loads in_data upper bits).
REQ-018 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold unchanged (stall).
REQ-019 flush=1 at an edge SHALL force out_valid=0, clear out_data[CTRL_W-1:0], empty any internal buffer; an input transfer on that edge SHALL be discarded.
REQ-020 Priority at an edge: rst > flush > transfers.
REQ-021 out_valid SHALL NOT fall without an output transfer, flush or rst.

Reset
REQ-022 During the edge with rst=1: out_valid=0, out_data=RST_VAL, internal buffer empty.
REQ-023 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-024 Reset mid-stall or mid-transfer SHALL discard all payloads with no output transfer reported.

Configuration
REQ-025 Macro PIPE_STAGE_SKID_EN selects buffering mode.
REQ-026 Without PIPE_STAGE_SKID_EN: in_ready = !rst && (out_ready || !out_valid), combinational; single register; throughput 1/cycle.
REQ-027 With PIPE_STAGE_SKID_EN: in_ready SHALL be a register output (no combinational path from out_ready); one skid register added; states EMPTY (out_valid=0), ONE (out_valid=1, skid empty), FULL (out_valid=1, skid full); in_ready=1 in EMPTY/ONE, 0 in FULL.
REQ-028 Skid transitions: EMPTY+in -> ONE; ONE+in+out -> ONE (pass-through); ONE+in, no out -> FULL (payload to skid); ONE+out, no in -> EMPTY; FULL+out -> ONE (skid moves to out_data, in_ready=1 next cycle); FULL, no out -> FULL; flush from any state -> EMPTY.
REQ-029 Both modes SHALL sustain 1 transfer/cycle with out_ready held high.

Verification
REQ-030 rst=1 two cycles, RST_VAL=32'hDEAD_0000 -> out_valid=0, out_data=32'hDEAD_0000, in_ready=0; after release in_ready=1.
REQ-031 Stream 0x11,0x22,0x33 back-to-back, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, 1-cycle latency.
REQ-032 Hold 0x44 at output, out_ready=0 for 3 cycles while in_valid=1 with 0x55 -> out_data stays 0x44; no-skid in_ready=0 all 3 cycles; skid in_ready=0 from 2nd cycle; after out_ready=1 outputs 0x44 then 0x55.
REQ-033 flush with out_valid=1 (0x0000_000F) and in_valid=1 (0x66) -> next cycle out_valid=0, out_data[3:0]=0, 0x66 never emerges.
REQ-034 Skid build: FULL state, assert out_ready and in_valid same edge -> out_data=skid payload, state ONE, new input not accepted that edge.
REQ-035 Random valid/ready toggling 10k cycles, both macro settings -> scoreboard order and count match, no loss outside flush.
